// File: rtl/select_32bit_pkg.sv
// Shared constants for the dual carry-select 32-bit adder: operand width,
// block count and the two block-width tables (LSB block first).
package select_32bit_pkg;

  localparam int WIDTH      = 32;
  localparam int NUM_BLOCKS = 6;

  localparam int PRIM_WIDTHS [NUM_BLOCKS] = '{4, 4, 6, 6, 6, 6};
  localparam int ALT_WIDTHS  [NUM_BLOCKS] = '{2, 4, 5, 6, 7, 8};

  typedef enum logic {
    ADDER_PRIM = 1'b0,
    ADDER_ALT  = 1'b1
  } adderKind_t;

  function automatic int blockWidth(adderKind_t kind, int idx);
    return (kind == ADDER_ALT) ? ALT_WIDTHS[idx] : PRIM_WIDTHS[idx];
  endfunction

  // Bit position of a block's LSB: running sum of the widths below it.
  function automatic int blockLsb(adderKind_t kind, int idx);
    int lsb;
    lsb = 0;
    for (int i = 0; i < idx; i++) lsb += blockWidth(kind, i);
    return lsb;
  endfunction

endpackage

// File: rtl/select_32bit_rca_block.sv
// N-bit ripple-carry adder built from discrete XOR/AND/OR gates so every
// full-adder gate is a distinct, observable net.
module rca_block #(
  parameter int N = 4
) (
  input  logic           [N-1:0] a,
  input  logic           [N-1:0] b,
  input  logic                   cin,
  output wire logic      [N-1:0] sum,
  output logic                   cout
);

  wire [N:0] carry;

  assign carry[0] = cin;

  for (genvar k = 0; k < N; k++) begin : gBit
    wire axb;
    wire gen;
    wire prop;
    xor uXorP   (axb, a[k], b[k]);
    xor uXorS   (sum[k], axb, carry[k]);
    and uAndG   (gen, a[k], b[k]);
    and uAndP   (prop, axb, carry[k]);
    or  uOrC    (carry[k+1], gen, prop);
  end

  assign cout = carry[N];

endmodule

// File: rtl/select_32bit.sv
// Two independent carry-select adders computing a+b, each with its own block
// partition; results and carries are registered with one cycle of latency.
module select_32bit
  import select_32bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      s,
  output logic [WIDTH-1:0]      s_alt,
  output logic                  cout,
  output logic                  cout_alt,
  output logic [NUM_BLOCKS-1:0] blockCoutPrim,
  output logic [NUM_BLOCKS-1:0] blockCoutAlt
);

  logic [1:0][WIDTH-1:0]      sumComb;
  logic [1:0][NUM_BLOCKS-1:0] carryComb;

  // Adder 0 is the primary partition, adder 1 the alternate; no gates are shared.
  for (genvar g = 0; g < 2; g++) begin : gAdder
    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : gBlk
      localparam adderKind_t KIND = adderKind_t'(g);
      localparam int W   = blockWidth(KIND, i);
      localparam int LSB = blockLsb(KIND, i);

      logic         blkCout;
      logic [W-1:0] blkSum;

      if (i == 0) begin : gFirst
        rca_block #(.N(W)) uChain (
          .a    (a[LSB +: W]),
          .b    (b[LSB +: W]),
          .cin  (1'b0),
          .sum  (blkSum),
          .cout (blkCout)
        );
      end else begin : gSel
        logic [W-1:0] sum0;
        logic [W-1:0] sum1;
        logic         cout0;
        logic         cout1;

        rca_block #(.N(W)) uChain0 (
          .a    (a[LSB +: W]),
          .b    (b[LSB +: W]),
          .cin  (1'b0),
          .sum  (sum0),
          .cout (cout0)
        );

        rca_block #(.N(W)) uChain1 (
          .a    (a[LSB +: W]),
          .b    (b[LSB +: W]),
          .cin  (1'b1),
          .sum  (sum1),
          .cout (cout1)
        );

        // The previous block's carry picks which speculative result is real.
        assign blkSum  = gBlk[i-1].blkCout ? sum1  : sum0;
        assign blkCout = gBlk[i-1].blkCout ? cout1 : cout0;
      end

      assign sumComb[g][LSB +: W] = blkSum;
      assign carryComb[g][i]      = blkCout;
    end
  end

  assign blockCoutPrim = carryComb[0];
  assign blockCoutAlt  = carryComb[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      s_alt    <= '0;
      cout     <= 1'b0;
      cout_alt <= 1'b0;
    end else begin
      s        <= sumComb[0];
      s_alt    <= sumComb[1];
      cout     <= carryComb[0][NUM_BLOCKS-1];
      cout_alt <= carryComb[1][NUM_BLOCKS-1];
    end
  end

endmodule

// File: tb/tb_select_32bit.sv
// Randomised scoreboard bench for select_32bit: operands are issued on the
// falling edge, expected 33-bit sums queue up and a monitor checks after each rise.
module tb_select_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] s;
  logic [31:0] s_alt;
  logic        cout;
  logic        cout_alt;
  logic [5:0]  blockCoutPrim;
  logic [5:0]  blockCoutAlt;

  logic [32:0] exp_q[$];
  int checkCount = 0;
  int passCount  = 0;

  // Cumulative block boundaries: carry out of block i leaves bit position k.
  int primBounds [6] = '{4, 8, 14, 20, 26, 32};
  int altBounds  [6] = '{2, 6, 11, 17, 24, 32};

  select_32bit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .b             (b),
    .s             (s),
    .s_alt         (s_alt),
    .cout          (cout),
    .cout_alt      (cout_alt),
    .blockCoutPrim (blockCoutPrim),
    .blockCoutAlt  (blockCoutAlt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic logic [32:0] refSum(input logic [31:0] va, input logic [31:0] vb);
    return {1'b0, va} + {1'b0, vb};
  endfunction

  // Carry out of the low k bits is bit k of the sum of the low k bits.
  function automatic logic [5:0] refCarries(input bit alt, input logic [31:0] va,
                                            input logic [31:0] vb);
    logic [5:0]  r;
    logic [63:0] mask;
    logic [63:0] t;
    int          k;
    for (int i = 0; i < 6; i++) begin
      k    = alt ? altBounds[i] : primBounds[i];
      mask = (64'd1 << k) - 64'd1;
      t    = ({32'd0, va} & mask) + ({32'd0, vb} & mask);
      r[i] = t[k];
    end
    return r;
  endfunction

  task automatic checkZero(input string tag);
    check({tag, "_s"},        {1'b0, s},      33'd0);
    check({tag, "_s_alt"},    {1'b0, s_alt},  33'd0);
    check({tag, "_cout"},     33'(cout),      33'd0);
    check({tag, "_cout_alt"}, 33'(cout_alt),  33'd0);
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    if (rst_n) exp_q.push_back(refSum(va, vb));
    #1;
    check("blk_carry_prim", 33'(blockCoutPrim), 33'(refCarries(1'b0, va, vb)));
    check("blk_carry_alt",  33'(blockCoutAlt),  33'(refCarries(1'b1, va, vb)));
  endtask

  // Monitor: one registered result per rising edge while operands are pending.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("s",        {1'b0, s},      {1'b0, e[31:0]});
        check("cout",     33'(cout),      33'(e[32]));
        check("s_alt",    {1'b0, s_alt},  {1'b0, e[31:0]});
        check("cout_alt", 33'(cout_alt),  33'(e[32]));
      end
    end
  end

  initial begin
    logic [31:0] dirA [10];
    logic [31:0] dirB [10];
    logic [31:0] ra;
    logic [31:0] rb;
    int          drained;

    dirA = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000,
             32'hFFFFFFFF, 32'h12345678, 32'h98765432, 32'h12378945, 32'h12378945};
    dirB = '{32'h00000001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'h98765432, 32'h12345678, 32'h98746512, 32'hFFFFFFFF};

    // Reset: outputs clear without any clock edge and stay clear across edges.
    #2 rst_n = 1'b0;
    #1 checkZero("rst_async");
    @(posedge clk);
    #1 checkZero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) drive(dirA[i], dirB[i]);

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = ~ra;
        1:       rb = ~ra + 32'd1;
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      drive(ra, rb);
    end

    // Reset mid-operation: the operand pair issued just before is discarded.
    drive(32'hDEADBEEF, 32'h11111111);
    @(negedge clk);
    a = 32'h0F0F0F0F;
    b = 32'h01010101;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 checkZero("rst_midop");
    @(posedge clk);
    #1 checkZero("rst_midop_edge");
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h80000000;
    b = 32'h80000001;
    exp_q.push_back(refSum(a, b));
    drive(32'h7FFFFFFF, 32'h00000001);
    drive(32'hA5A5A5A5, 32'h5A5A5A5B);

    drained = 0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() == 0) drained = 1;
    check("drain", 33'(drained), 33'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/select_32bit.md
SELECT_32BIT -- requirements
Module: select_32bit

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  32  addend A, unsigned.
REQ-005 b  input  32  addend B, unsigned.
REQ-006 s  output  32  registered sum, primary carry-select adder.
REQ-007 s_alt  output  32  registered sum, alternate carry-select adder.
REQ-008 cout  output  1  registered carry-out, primary adder.
REQ-009 cout_alt  output  1  registered carry-out, alternate adder.

Function
REQ-010 SHALL compute {cout,s} = a + b (33-bit unsigned result, carry-in fixed 0) via primary adder.
REQ-011 SHALL compute {cout_alt,s_alt} = a + b via alternate adder, independent logic, no shared gates with the primary adder.
REQ-012 Both adders SHALL be pure combinational; their results SHALL be captured in output registers on each rising clk edge.
REQ-013 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N; a new operand pair is accepted every cycle; no handshake.
REQ-014 Primary adder SHALL use 6 carry-select blocks of widths 4,4,6,6,6,6 (LSB first); first block is a single ripple-carry chain with cin=0.
REQ-015 Alternate adder SHALL use 6 blocks of widths 2,4,5,6,7,8 (LSB first); first block is a single ripple-carry chain with cin=0.
REQ-016 Each non-first block SHALL compute sum/carry twice in parallel ripple chains (cin=0 and cin=1) and select both via a 2:1 mux driven by the previous block carry-out.
REQ-017 Each adder SHALL expose 6 internal block carry-out nets; the 6th SHALL equal that adder's carry-out.
REQ-018 Ripple chains SHALL be built from explicit full-adder gate primitives (XOR/AND/OR) so per-gate toggle activity is countable in simulation.
REQ-019 Wrap-around: sums ≥ 2^32 SHALL drop bit 32 into cout/cout_alt with s holding the low 32 bits.
REQ-020 s==s_alt and cout==cout_alt SHALL hold on every cycle outside reset for all inputs.

Reset
REQ-021 While rst_n=0, s, s_alt, cout, cout_alt SHALL be 0 immediately, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; first valid result appears one edge after rst_n deasserts.
REQ-023 No other state exists.

Structure
REQ-024 Shared package SHALL hold WIDTH=32, NUM_BLOCKS=6 and both block-width tables as constants.
REQ-025 One sub-module SHALL be used: rca_block (parameterized N-bit ripple-carry adder with cin, sum, cout), instantiated for all chains.
REQ-026 Mux and output registers SHALL reside in select_32bit.

Verification
REQ-027 a=0x00000001, b=0x00000001 -> s=s_alt=0x00000002, cout=cout_alt=0, one cycle later.
REQ-028 a=0xFFFFFFFF, b=0x00000000 -> s=0xFFFFFFFF, cout=0; then b=0x00000001 -> s=0x00000000, cout=1 (full carry propagation through all blocks); swapped operands give identical results.
REQ-029 a=0xFFFFFFFF, b=0xFFFFFFFF -> s=0xFFFFFFFE, cout=1.
REQ-030 a=0x12345678, b=0x98765432 (and swapped) -> s=0xAAAAAAAA, cout=0; a=0x12378945, b=0x98746512 -> s=0xAAABEE57, cout=0; a=0x12378945, b=0xFFFFFFFF -> s=0x12378944, cout=1.
REQ-031 Drive rst_n=0 between edges with nonzero outputs -> all outputs 0 without a clock edge; release -> correct sum after next edge.
REQ-032 10,000 random back-to-back pairs -> each cycle s, s_alt equal golden (a+b)[31:0] and cout, cout_alt equal bit 32, one-cycle delayed.
